// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one requester at a time, tracks its single
// read/write handshake, and force-releases the bus if the grantee stalls.
module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            bus_busy,
    input  logic            read_q,
    input  logic            write_q,
    input  logic            read_dn,
    input  logic            write_dn,
    output logic            timeout_err,
    output logic [ID_W-1:0] err_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic            op_rd_q, op_rd_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            timeout_err_q, timeout_err_d;
    logic [ID_W-1:0] err_id_q, err_id_d;

    logic            found;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] scan_idx;
    logic            expired;

    // Round-robin scan starting at ptr; index arithmetic wraps because NREQ is a power of two.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ptr_q + ID_W'(i);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    assign expired = (timer_q == TO_W'(TIMEOUT - 1));

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        op_rd_d       = op_rd_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d    = NREQ'(1) << sel;
                    gnt_id_d = sel;
                    timer_d  = '0;
                    state_d  = GRANT;
                end
            end

            GRANT: begin
                timer_d = timer_q + TO_W'(1);
                if (read_q || write_q) begin
                    op_rd_d = read_q;
                    if (read_q ? read_dn : write_dn) begin
                        gnt_d   = '0;
                        state_d = RELEASE;
                    end else if (expired) begin
                        gnt_d         = '0;
                        state_d       = RELEASE;
                        timeout_err_d = 1'b1;
                        err_id_d      = gnt_id_q;
                    end else begin
                        state_d = XFER;
                    end
                end else if (!req[gnt_id_q]) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else if (expired) begin
                    gnt_d         = '0;
                    state_d       = RELEASE;
                    timeout_err_d = 1'b1;
                    err_id_d      = gnt_id_q;
                end
            end

            XFER: begin
                timer_d = timer_q + TO_W'(1);
                // Only the completion matching the latched direction ends the transfer.
                if (op_rd_q ? read_dn : write_dn) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else if (expired) begin
                    gnt_d         = '0;
                    state_d       = RELEASE;
                    timeout_err_d = 1'b1;
                    err_id_d      = gnt_id_q;
                end
            end

            RELEASE: begin
                gnt_d   = '0;
                ptr_d   = gnt_id_q + ID_W'(1);
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            timer_q       <= '0;
            op_rd_q       <= 1'b0;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            op_rd_q       <= op_rd_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign bus_busy    = |gnt_q;
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NREQ=4, TIMEOUT=8): reset, latency, zero-wait,
// withdrawal, direction mismatch, reset mid-transfer, round-robin order, timeout.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       bus_busy;
    logic       read_q;
    logic       write_q;
    logic       read_dn;
    logic       write_dn;
    logic       timeout_err;
    logic [1:0] err_id;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(
        .NREQ   (4),
        .ID_W   (2),
        .TIMEOUT(8),
        .TO_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .bus_busy   (bus_busy),
        .read_q     (read_q),
        .write_q    (write_q),
        .read_dn    (read_dn),
        .write_dn   (write_dn),
        .timeout_err(timeout_err),
        .err_id     (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [3:0] exp_gnt, input logic exp_terr);
        check({tag, ".gnt"}, 8'(gnt), 8'(exp_gnt));
        check({tag, ".busy"}, 8'(bus_busy), 8'(|exp_gnt));
        check({tag, ".terr"}, 8'(timeout_err), 8'(exp_terr));
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        rst = 1'b1; req = 4'b1111;
        read_q = 1'b0; write_q = 1'b0; read_dn = 1'b0; write_dn = 1'b0;

        // Reset held two cycles with all requests asserted.
        tick(); check_bus("rst1", 4'b0000, 1'b0);
        tick(); check_bus("rst2", 4'b0000, 1'b0);
        check("rst.err_id", 8'(err_id), 8'd0);
        check("rst.gnt_id", 8'(gnt_id), 8'd0);
        rst = 1'b0;
        tick(); check_bus("first_gnt", 4'b0001, 1'b0);
        check("first_gnt.id", 8'(gnt_id), 8'd0);

        // Grantee 0 withdraws in GRANT: release without error, ptr -> 1.
        req = 4'b0000;
        tick(); check_bus("withdraw.rel", 4'b0000, 1'b0);
        tick(); check_bus("withdraw.idle", 4'b0000, 1'b0);
        check("withdraw.id_hold", 8'(gnt_id), 8'd0);

        // Single-cycle latency and zero-wait read; ptr -> 3 afterwards.
        req = 4'b0100;
        tick(); check_bus("lat.gnt", 4'b0100, 1'b0);
        check("lat.id", 8'(gnt_id), 8'd2);
        read_q = 1'b1; read_dn = 1'b1;
        tick(); check_bus("zw.rel", 4'b0000, 1'b0);
        read_q = 1'b0; read_dn = 1'b0; req = 4'b0000;
        tick(); check_bus("zw.idle", 4'b0000, 1'b0);

        // Requester 1 writes; a stray read_dn must not end the transfer.
        req = 4'b0010;
        tick(); check_bus("mm.gnt", 4'b0010, 1'b0);
        write_q = 1'b1;
        tick(); check_bus("mm.xfer", 4'b0010, 1'b0);
        write_q = 1'b0; read_dn = 1'b1;
        tick(); check_bus("mm.ignore_rd", 4'b0010, 1'b0);
        read_dn = 1'b0; write_dn = 1'b1;
        tick(); check_bus("mm.rel", 4'b0000, 1'b0);
        write_dn = 1'b0;
        tick(); check_bus("mm.idle", 4'b0000, 1'b0);

        // ptr=2 now, so req 1010 selects 3; reset in XFER with read_dn ignored.
        req = 4'b1010;
        tick(); check_bus("rx.gnt", 4'b1000, 1'b0);
        check("rx.id", 8'(gnt_id), 8'd3);
        read_q = 1'b1;
        tick(); check_bus("rx.xfer", 4'b1000, 1'b0);
        read_q = 1'b0; rst = 1'b1; read_dn = 1'b1;
        tick(); check_bus("rx.rst", 4'b0000, 1'b0);
        rst = 1'b0; read_dn = 1'b0;
        tick(); check_bus("rx.ptr0", 4'b0010, 1'b0);
        check("rx.ptr0.id", 8'(gnt_id), 8'd1);
        req = 4'b0000;
        tick(); check_bus("rx.rel", 4'b0000, 1'b0);
        tick();

        // Restart from ptr=0 and run the round-robin write sequence.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(); check_bus($sformatf("rr%0d.gnt", k), rr_exp[k], 1'b0);
            check($sformatf("rr%0d.id", k), 8'(gnt_id), 8'(k % 4));
            write_q = 1'b1;
            tick(); check_bus($sformatf("rr%0d.xfer", k), rr_exp[k], 1'b0);
            write_q = 1'b0;
            tick(); check_bus($sformatf("rr%0d.wait", k), rr_exp[k], 1'b0);
            write_dn = 1'b1;
            tick(); check_bus($sformatf("rr%0d.rel", k), 4'b0000, 1'b0);
            write_dn = 1'b0;
            tick(); check_bus($sformatf("rr%0d.idle", k), 4'b0000, 1'b0);
        end

        // ptr=1: req 1001 selects 3, which reads and never completes.
        req = 4'b1001;
        tick(); check_bus("to.gnt", 4'b1000, 1'b0);
        read_q = 1'b1;
        tick(); check_bus("to.c1", 4'b1000, 1'b0);
        read_q = 1'b0;
        for (int c = 2; c < 8; c++) begin
            tick(); check_bus($sformatf("to.c%0d", c), 4'b1000, 1'b0);
        end
        tick(); check_bus("to.fire", 4'b0000, 1'b1);
        check("to.err_id", 8'(err_id), 8'd3);
        tick(); check_bus("to.idle", 4'b0000, 1'b0);
        check("to.err_id_hold", 8'(err_id), 8'd3);
        tick(); check_bus("to.next", 4'b0001, 1'b0);
        check("to.next.id", 8'(gnt_id), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
